// File: rtl/uga_dyna_status_rx_if.sv
// Byte stream from the UART receiver into the Dynamixel status parser.
// master drives the byte strobe; slave (the parser) consumes it.
interface uga_dyna_status_rx_if;
   logic       rx_en;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_err;

   modport master (output rx_en, rx_data, rx_valid, rx_err);
   modport slave  (input  rx_en, rx_data, rx_valid, rx_err);
endinterface

// File: rtl/uga_dyna_status_rx.sv
// Dynamixel 1.0 status packet parser (FF FF ID LEN ERR P0..Pn CHK) with length/checksum/timeout checks.
// Optional macro UGA_DYNA_RX_ID_FILTER_EN adds expect_id and suppresses pkt_valid for foreign IDs.
module uga_dyna_status_rx #(
   parameter int MAX_PARAMS  = 4,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic                      clk,
   input  logic                      rst_n,
   uga_dyna_status_rx_if.slave       rx,
`ifdef UGA_DYNA_RX_ID_FILTER_EN
   input  logic [7:0]                expect_id,
`endif
   output logic [7:0]                stat_id,
   output logic [7:0]                stat_error,
   output logic [3:0]                stat_nparams,
   output logic [8*MAX_PARAMS-1:0]   stat_params,
   output logic                      pkt_valid,
   output logic                      chk_fail,
   output logic                      len_fail,
   output logic                      frame_fail,
   output logic                      busy
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_HDR2, S_ID, S_LEN, S_ERR, S_PARAM, S_CHK
   } state_t;

   state_t                         state_q, state_d;
   logic [CNT_W-1:0]               cnt_q, cnt_d;
   logic [7:0]                     sum_q, sum_d;
   logic [7:0]                     id_q, id_d;
   logic [7:0]                     err_q, err_d;
   logic [3:0]                     npar_q, npar_d;
   logic [3:0]                     idx_q, idx_d;
   logic [MAX_PARAMS-1:0][7:0]     par_q, par_d;
   logic [8*MAX_PARAMS-1:0]        par_mask;
   logic                           pkt_q, pkt_d;
   logic                           chkf_q, chkf_d;
   logic                           lenf_q, lenf_d;
   logic                           frmf_q, frmf_d;
   logic                           load_stat;
   logic                           accept;
   logic                           id_ok;

   assign accept = rx.rx_en & rx.rx_valid;

`ifdef UGA_DYNA_RX_ID_FILTER_EN
   assign id_ok = (id_q == expect_id) || (id_q == 8'hFE);
`else
   assign id_ok = 1'b1;
`endif

   // Slots beyond the current packet's parameter count read as zero.
   always_comb begin
      par_mask = '0;
      for (int i = 0; i < MAX_PARAMS; i++) begin
         if (4'(i) < npar_q) par_mask[i*8 +: 8] = par_q[i];
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      sum_d     = sum_q;
      id_d      = id_q;
      err_d     = err_q;
      npar_d    = npar_q;
      idx_d     = idx_q;
      par_d     = par_q;
      pkt_d     = 1'b0;
      chkf_d    = 1'b0;
      lenf_d    = 1'b0;
      frmf_d    = 1'b0;
      load_stat = 1'b0;

      if (!rx.rx_en) begin
         state_d = S_IDLE;
         cnt_d   = '0;
      end else if (accept) begin
         cnt_d = '0;
         if (rx.rx_err && (state_q != S_IDLE)) begin
            frmf_d  = 1'b1;
            state_d = S_IDLE;
         end else begin
            unique case (state_q)
               S_IDLE: if (rx.rx_data == 8'hFF) state_d = S_HDR2;
               S_HDR2: state_d = (rx.rx_data == 8'hFF) ? S_ID : S_IDLE;
               S_ID: begin
                  if (rx.rx_data != 8'hFF) begin
                     id_d    = rx.rx_data;
                     sum_d   = rx.rx_data;
                     state_d = S_LEN;
                  end
               end
               S_LEN: begin
                  if ((rx.rx_data < 8'd2) || (rx.rx_data > 8'(MAX_PARAMS + 2))) begin
                     lenf_d  = 1'b1;
                     state_d = S_IDLE;
                  end else begin
                     npar_d  = 4'(rx.rx_data - 8'd2);
                     sum_d   = sum_q + rx.rx_data;
                     state_d = S_ERR;
                  end
               end
               S_ERR: begin
                  err_d   = rx.rx_data;
                  sum_d   = sum_q + rx.rx_data;
                  idx_d   = '0;
                  state_d = (npar_q != 4'd0) ? S_PARAM : S_CHK;
               end
               S_PARAM: begin
                  for (int i = 0; i < MAX_PARAMS; i++) begin
                     if (idx_q == 4'(i)) par_d[i] = rx.rx_data;
                  end
                  sum_d = sum_q + rx.rx_data;
                  idx_d = idx_q + 4'd1;
                  if (idx_q == npar_q - 4'd1) state_d = S_CHK;
               end
               S_CHK: begin
                  if (rx.rx_data == ~sum_q) begin
                     load_stat = id_ok;
                     pkt_d     = id_ok;
                  end else begin
                     chkf_d = 1'b1;
                  end
                  state_d = S_IDLE;
               end
               default: state_d = S_IDLE;
            endcase
         end
      end else if (state_q != S_IDLE) begin
         // A byte on the expiry cycle takes the accept branch above, so it wins.
         if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
            frmf_d  = 1'b1;
            state_d = S_IDLE;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         sum_q        <= '0;
         id_q         <= '0;
         err_q        <= '0;
         npar_q       <= '0;
         idx_q        <= '0;
         par_q        <= '0;
         pkt_q        <= 1'b0;
         chkf_q       <= 1'b0;
         lenf_q       <= 1'b0;
         frmf_q       <= 1'b0;
         stat_id      <= '0;
         stat_error   <= '0;
         stat_nparams <= '0;
         stat_params  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         id_q    <= id_d;
         err_q   <= err_d;
         npar_q  <= npar_d;
         idx_q   <= idx_d;
         par_q   <= par_d;
         pkt_q   <= pkt_d;
         chkf_q  <= chkf_d;
         lenf_q  <= lenf_d;
         frmf_q  <= frmf_d;
         if (load_stat) begin
            stat_id      <= id_q;
            stat_error   <= err_q;
            stat_nparams <= npar_q;
            stat_params  <= par_mask;
         end
      end
   end

   assign pkt_valid  = pkt_q;
   assign chk_fail   = chkf_q;
   assign len_fail   = lenf_q;
   assign frame_fail = frmf_q;
   assign busy       = (state_q != S_IDLE);

endmodule

// File: doc/uga_dyna_status_rx.md
Name: uga_dyna_status_rx

Overview:
- Receive-side packet parser for the Dynamixel MX-28T half-duplex TTL bus.
- Consumes bytes from the UART receiver while the bus is in RX direction (dyna_bus_oen=1).
- Decodes Dynamixel 1.0 status packets of the form FF FF ID LEN ERR P0..Pn CHK and checks length and checksum.
- Presents ID, error byte and parameters to uga_dyna_core / register bank with one-cycle status pulses.

Parameters:
- MAX_PARAMS, 4, maximum parameter bytes stored per packet (1..8).
- TIMEOUT_CYC, 50000, inter-byte timeout in clk cycles (1 ms at 50 MHz).

Ports:
- clk  input  1  50 MHz clock.
- rst_n  input  1  synchronous active-low reset.
- rx_en  input  1  parser enable; tied to dyna_bus_oen (1=RX).
- rx_data  input  8  received byte from UART.
- rx_valid  input  1  one-cycle strobe, rx_data valid.
- rx_err  input  1  framing/parity error flag, qualified by rx_valid.
- stat_id  output  8  ID of last good packet.
- stat_error  output  8  ERR byte of last good packet.
- stat_nparams  output  4  number of parameters of last good packet.
- stat_params  output  8*MAX_PARAMS  parameters; P0 in bits [7:0].
- pkt_valid  output  1  pulse: good packet, stat_* updated the same cycle.
- chk_fail  output  1  pulse: checksum mismatch.
- len_fail  output  1  pulse: LEN<2 or LEN>MAX_PARAMS+2.
- frame_fail  output  1  pulse: rx_err received or timeout.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is synchronous and active-low.
- Reset values: every output 0; state IDLE; timeout counter 0; checksum accumulator 0.
- Byte acceptance: only cycles with rx_valid=1 and rx_en=1 are processed.
- rx_en=0: state forced to IDLE, counter cleared, no pulses; a packet in progress is discarded silently.
- Disabling rx_en mid-packet therefore acts like a local reset, except stat_* keep their values.
- States: IDLE, HDR2, ID, LEN, ERR, PARAM, CHK.
  - IDLE: FF goes to HDR2; any other byte is ignored.
  - HDR2: FF goes to ID; any other byte goes to IDLE.
  - ID: FF stays in ID (extra header byte). Any other byte is stored in id_r, sum=byte, next LEN.
  - LEN:
    - LEN<2 or LEN>MAX_PARAMS+2: len_fail pulse, go to IDLE.
    - Otherwise: nparams=LEN-2, sum+=byte, next ERR.
  - ERR: store err_r, sum+=byte. Next PARAM if nparams>0, else CHK.
  - PARAM: store the byte at index idx, sum+=byte, idx++. When idx reaches nparams-1, next CHK.
  - CHK: compare against (~sum)[7:0]; next IDLE in both cases.
    - Match: next cycle pkt_valid=1 and stat_* loaded from the internal registers.
    - Mismatch: next cycle chk_fail=1; stat_* unchanged.
- Arithmetic: sum is 8-bit modulo-256 (overflow discarded); idx is 4-bit.
- Parameter slots not written by the current packet are forced to 0 in stat_params.
- rx_err=1 on an accepted byte in any state other than IDLE: frame_fail pulse, go to IDLE. rx_err in IDLE is ignored.
- Timeout:
  - The counter runs while the state is not IDLE and clears on every accepted byte.
  - When it reaches TIMEOUT_CYC-1: frame_fail pulse, go to IDLE, counter cleared.
  - A byte arriving on the same cycle as the timeout wins; no timeout is flagged.
- Pulses: all status pulses last exactly one cycle, occur one cycle after the causing byte, and are mutually exclusive.
- Latency: CHK byte strobe at cycle N gives pkt_valid at N+1. Back-to-back packets with zero idle cycles are supported.

Optional Feature:
- Macro: UGA_DYNA_RX_ID_FILTER_EN.
- Defined:
  - Adds input port expect_id [7:0].
  - If the ID byte is not equal to expect_id and not 0xFE, parsing continues and the checksum is checked, but the pkt_valid pulse is suppressed. stat_* stay unchanged and no status pulse is generated.
  - len_fail, chk_fail and frame_fail behave as normal.
- Undefined: no expect_id port; every well-formed packet produces pkt_valid.

Test Plan:
1. Bytes FF FF 01 02 00 FC (rx_en=1) -> pkt_valid one cycle after FC; stat_id=01, stat_error=00, stat_nparams=0, stat_params=0.
2. FF FF 01 04 00 20 03 D7 -> pkt_valid; stat_nparams=2, stat_params[15:0]=0x0320. The same packet with last byte D8 -> chk_fail; stat_* keep previous values.
3. FF FF FF 01 02 00 FC (triple header) -> pkt_valid, stat_id=01. FF FF 01 07 ... with MAX_PARAMS=4 -> len_fail after the LEN byte, busy=0 the following cycle.
4. FF FF 01 04 then no bytes -> frame_fail exactly TIMEOUT_CYC cycles after the last byte. Repeat with a byte at cycle TIMEOUT_CYC-1 -> no frame_fail.
5. rx_err=1 on the ERR byte -> frame_fail. rx_en dropped mid-packet -> busy=0 next cycle with no pulse; a new packet after rx_en returns to 1 parses correctly.
6. With UGA_DYNA_RX_ID_FILTER_EN defined and expect_id=03: packet ID 01 with a valid checksum -> no pulses; packet ID 03 -> pkt_valid.
